// File: rtl/is_array_ctrl.sv
// Sequencer for an input-stationary ROWS x COLS systolic array: clear, activation load, skewed weight stream, scan drain.
// Optional performance counters (stall_cnt, tile_cycles) are built when IS_ARRAY_CTRL_PERF_EN is defined.
module is_array_ctrl #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int STAGE = 0,
    parameter int KW    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [KW-1:0]   cfg_k,
    input  logic            wei_valid,
    output logic            wei_rd_en,
    output logic            reg_clear,
    output logic            cell_sc_en,
    output logic [ROWS-1:0] cell_en,
    output logic            pipeline_en,
    output logic            cscan_en,
    output logic            out_valid,
    output logic            busy,
    output logic            done
`ifdef IS_ARRAY_CTRL_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     tile_cycles
`endif
);

    // One counter is shared by LOAD, COMPUTE (slot index) and DRAIN; sized to hold k_reg+ROWS as well as the fixed phase lengths.
    localparam int CW = KW + $clog2(ROWS + 2*COLS + STAGE + 4) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state, state_next;
    logic [KW-1:0]  k_reg, k_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [CW-1:0]  cnt_inc;
    logic [CW-1:0]  k_ext;
    logic [CW-1:0]  last_slot;
    logic           need_wei;
    logic           advance;

    assign k_ext     = CW'(k_reg);
    assign last_slot = k_ext + CW'(ROWS) - CW'(2);
    assign need_wei  = (cnt < k_ext);
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            k_reg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            k_reg <= k_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        k_next      = k_reg;
        cnt_next    = cnt;
        advance     = 1'b0;
        wei_rd_en   = 1'b0;
        reg_clear   = 1'b0;
        cell_sc_en  = 1'b0;
        cell_en     = '0;
        pipeline_en = 1'b0;
        cscan_en    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    k_next     = cfg_k;
                    cnt_next   = '0;
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy       = 1'b1;
                reg_clear  = 1'b1;
                cnt_next   = '0;
                state_next = (k_reg == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                busy       = 1'b1;
                cell_sc_en = 1'b1;
                if (cnt == CW'(2*COLS - 1)) begin
                    cnt_next   = '0;
                    state_next = S_COMPUTE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            S_COMPUTE: begin
                busy = 1'b1;
                // Row r sees weights k_reg slots long, starting r slots late.
                for (int r = 0; r < ROWS; r++) begin
                    cell_en[r] = (cnt >= CW'(r)) && (cnt <= CW'(r) + k_ext - CW'(1));
                end
                if (need_wei) begin
                    if (wei_valid) begin
                        wei_rd_en   = 1'b1;
                        pipeline_en = 1'b1;
                        advance     = 1'b1;
                    end
                end else begin
                    pipeline_en = 1'b1;
                    advance     = 1'b1;
                end
                if (advance) begin
                    if (cnt == last_slot) begin
                        cnt_next   = '0;
                        state_next = S_DRAIN;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (cnt > CW'(STAGE)) begin
                    cscan_en  = 1'b1;
                    out_valid = 1'b1;
                end
                if (cnt == CW'(STAGE + COLS)) begin
                    cnt_next   = '0;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Zeroing k_reg makes the following CLEAR fall straight through to DONE.
        if (abort && (state != S_IDLE)) begin
            state_next  = S_CLEAR;
            cnt_next    = '0;
            k_next      = '0;
            wei_rd_en   = 1'b0;
            pipeline_en = 1'b0;
        end
    end

`ifdef IS_ARRAY_CTRL_PERF_EN
    // Counters restart whenever CLEAR is entered and freeze once the FSM is back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= '0;
            tile_cycles <= '0;
        end else if (state_next == S_CLEAR) begin
            stall_cnt   <= '0;
            tile_cycles <= '0;
        end else begin
            if ((state != S_IDLE) && (tile_cycles != '1)) begin
                tile_cycles <= tile_cycles + 32'd1;
            end
            if ((state == S_COMPUTE) && need_wei && !wei_valid && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_is_array_ctrl.sv
// Scoreboard bench for is_array_ctrl (ROWS=COLS=4, STAGE=0): per-cycle expected control vectors are queued with the stimulus.
// Performance counter checks are compiled in when IS_ARRAY_CTRL_PERF_EN is defined.
module tb_is_array_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] cfg_k;
    logic        wei_valid;
    logic        wei_rd_en;
    logic        reg_clear;
    logic        cell_sc_en;
    logic [3:0]  cell_en;
    logic        pipeline_en;
    logic        cscan_en;
    logic        out_valid;
    logic        busy;
    logic        done;
`ifdef IS_ARRAY_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] tile_cycles;
`endif

    is_array_ctrl #(.ROWS(4), .COLS(4), .STAGE(0), .KW(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .cfg_k       (cfg_k),
        .wei_valid   (wei_valid),
        .wei_rd_en   (wei_rd_en),
        .reg_clear   (reg_clear),
        .cell_sc_en  (cell_sc_en),
        .cell_en     (cell_en),
        .pipeline_en (pipeline_en),
        .cscan_en    (cscan_en),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done)
`ifdef IS_ARRAY_CTRL_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .tile_cycles (tile_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        start;
        logic        abort;
        logic        wei_valid;
        logic [15:0] cfg;
    } stim_t;

    stim_t       stim_q[$];
    logic [11:0] exp_q[$];
    int          checks;
    int          passed;

    // Observed vector: {wei_rd_en, reg_clear, cell_sc_en, cell_en[3:0], pipeline_en, cscan_en, out_valid, busy, done}
    logic [11:0] obs;
    assign obs = {wei_rd_en, reg_clear, cell_sc_en, cell_en, pipeline_en, cscan_en, out_valid, busy, done};

    function automatic logic [11:0] vec(logic wr, logic rc, logic sc, logic [3:0] ce,
                                        logic pe, logic cs, logic ov, logic bz, logic dn);
        return {wr, rc, sc, ce, pe, cs, ov, bz, dn};
    endfunction

    function automatic logic [3:0] ce_model(int s, int k);
        logic [3:0] v;
        v = '0;
        for (int r = 0; r < 4; r++) v[r] = (r <= s) && (s <= r + k - 1);
        return v;
    endfunction

    task automatic push(logic st, logic ab, logic wv, int k, logic [11:0] e);
        stim_t t;
        t.start     = st;
        t.abort     = ab;
        t.wei_valid = wv;
        t.cfg       = 16'(k);
        stim_q.push_back(t);
        exp_q.push_back(e);
    endtask

    // Expected tile trace derived from the phase lengths: 1 clear, 2*COLS load, k+ROWS-1 slots, STAGE+1 wait, COLS scans, done.
    task automatic push_tile(int k, int stall_slot, int stall_len, int abort_slot);
        push(1, 0, 1, k, '0);
        push(0, 0, 1, k, vec(0, 1, 0, 4'h0, 0, 0, 0, 1, 0));
        if (k == 0) begin
            push(0, 0, 1, k, vec(0, 0, 0, 4'h0, 0, 0, 0, 1, 1));
            push(0, 0, 1, k, '0);
            return;
        end
        for (int i = 0; i < 8; i++) push(0, 0, 1, k, vec(0, 0, 1, 4'h0, 0, 0, 0, 1, 0));
        for (int s = 0; s <= k + 2; s++) begin
            if (s < k && s == stall_slot)
                for (int j = 0; j < stall_len; j++) push(0, 0, 0, k, vec(0, 0, 0, ce_model(s, k), 0, 0, 0, 1, 0));
            if (s == abort_slot) begin
                push(0, 1, 1, k, vec(0, 0, 0, ce_model(s, k), 0, 0, 0, 1, 0));
                push(0, 0, 1, k, vec(0, 1, 0, 4'h0, 0, 0, 0, 1, 0));
                push(0, 0, 1, k, vec(0, 0, 0, 4'h0, 0, 0, 0, 1, 1));
                push(0, 0, 1, k, '0);
                return;
            end
            push(0, 0, 1, k, vec(logic'(s < k), 0, 0, ce_model(s, k), 1, 0, 0, 1, 0));
        end
        push(0, 0, 1, k, vec(0, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) push(0, 0, 1, k, vec(0, 0, 0, 4'h0, 0, 1, 1, 1, 0));
        push(0, 0, 1, k, vec(0, 0, 0, 4'h0, 0, 0, 0, 1, 1));
        push(0, 0, 1, k, '0);
    endtask

    // Applies the next queued stimulus just after a rising edge and returns observed/expected at the falling edge.
    task automatic applyStimulus(output logic [11:0] o, output logic [11:0] e);
        stim_t t;
        t         = stim_q.pop_front();
        e         = exp_q.pop_front();
        start     = t.start;
        abort     = t.abort;
        wei_valid = t.wei_valid;
        cfg_k     = t.cfg;
        @(negedge clk);
        o = obs;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        wei_valid = 1'b0;
        cfg_k     = '0;
        #12;
        checks++;
        if (obs !== 12'h000) $display("[TB] FAIL reset_outputs got=%h want=%h", obs, 12'h000);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_tile(string name, int k, int stall_slot, int stall_len, int abort_slot);
        logic [11:0] o, e;
        int cyc;
        push_tile(k, stall_slot, stall_len, abort_slot);
        cyc = 0;
        while (stim_q.size() > 0) begin
            applyStimulus(o, e);
            checks++;
            if (o !== e) $display("[TB] FAIL %s cycle %0d got=%b want=%b", name, cyc, o, e);
            else passed++;
            cyc++;
        end
    endtask

    task automatic test_back_to_back_start();
        logic [11:0] o, e;
        stim_t t;
        int idx[3];
        idx = '{5, 12, 21};
        push_tile(3, -1, 0, -1);
        foreach (idx[i]) begin
            t = stim_q[idx[i]];
            t.start = 1'b1;
            t.cfg   = 16'(7 + i);
            stim_q[idx[i]] = t;
        end
        for (int c = 0; stim_q.size() > 0; c++) begin
            applyStimulus(o, e);
            checks++;
            if (o !== e) $display("[TB] FAIL busy_start cycle %0d got=%b want=%b", c, o, e);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [11:0] o, e;
        push_tile(3, -1, 0, -1);
        for (int c = 0; c < 18; c++) begin
            applyStimulus(o, e);
            checks++;
            if (o !== e) $display("[TB] FAIL mid_drain_pre cycle %0d got=%b want=%b", c, o, e);
            else passed++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 12'h000) $display("[TB] FAIL mid_drain_reset got=%b want=%b", obs, 12'h000);
        else passed++;
        stim_q.delete();
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (obs !== 12'h000) $display("[TB] FAIL mid_drain_held got=%b want=%b", obs, 12'h000);
        else passed++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_tile("after_reset", 3, -1, 0, -1);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_tile("baseline", 3, -1, 0, -1);
`ifdef IS_ARRAY_CTRL_PERF_EN
        checks++;
        if (tile_cycles !== 32'd21) $display("[TB] FAIL baseline_tile_cycles got=%0d want=21", tile_cycles);
        else passed++;
`endif
        test_tile("stall", 3, 1, 2, -1);
`ifdef IS_ARRAY_CTRL_PERF_EN
        checks++;
        if (stall_cnt !== 32'd2) $display("[TB] FAIL stall_cnt got=%0d want=2", stall_cnt);
        else passed++;
        checks++;
        if (tile_cycles !== 32'd23) $display("[TB] FAIL stall_tile_cycles got=%0d want=23", tile_cycles);
        else passed++;
`endif
        test_tile("zero_k", 0, -1, 0, -1);
        test_tile("abort", 3, -1, 0, 2);
        test_tile("k1", 1, -1, 0, -1);
        test_back_to_back_start();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
